// File: rtl/fmadiv_pkg.sv
// Shared widths, state encoding and helpers for the iterative significand divider.
// Build option FMADIV_RADIX4_EN retires two quotient bits per BUSY cycle.
package fmadiv_pkg;

    localparam int unsigned NE    = 5;
    localparam int unsigned NF    = 10;
    localparam int unsigned BIAS  = 15;

    localparam int unsigned EW    = NE + 2;
    localparam int unsigned MW    = NF + 1;
    localparam int unsigned RW    = NF + 2;
    localparam int unsigned QBITS = NF + 3;

`ifdef FMADIV_RADIX4_EN
    localparam int unsigned ITERS = (QBITS + 1) / 2;
    localparam int unsigned QW    = 2 * ITERS;
`else
    localparam int unsigned ITERS = QBITS;
    localparam int unsigned QW    = QBITS;
`endif

    localparam int unsigned CW    = $clog2(ITERS + 1);

    // Quotient bits produced beyond QBITS; they only feed the sticky bit.
    localparam int unsigned DROP      = QW - QBITS;
    localparam logic [QW-1:0] DROP_MASK = QW'((64'd1 << DROP) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic          sticky;
        logic          dz;
        logic          nv;
    } res_t;

    function automatic logic [EW-1:0] quot_exp(input logic [NE-1:0] xe, input logic [NE-1:0] ye);
        return EW'(xe) - EW'(ye) + EW'(BIAS);
    endfunction

endpackage

// File: rtl/fmadiv_iter_step.sv
// One combinational restoring-division step: compare, conditionally subtract, shift.
module fmadiv_iter_step
    import fmadiv_pkg::*;
(
    input  logic [RW-1:0] r,
    input  logic [MW-1:0] d,
    output logic          q_bit_c,
    output logic [RW-1:0] r_next_c
);

    logic [RW:0] diff;

    // Pre-shift partial remainder is always below D, so its top bit is zero.
    always_comb begin
        diff     = {1'b0, r} - (RW+1)'(d);
        q_bit_c  = ~diff[RW];
        r_next_c = q_bit_c ? {diff[RW-2:0], 1'b0} : {r[RW-2:0], 1'b0};
    end

endmodule

// File: rtl/fmadiv_iter.sv
// Iterative unrounded significand divider X/Y with valid/ready handshakes.
// Define FMADIV_RADIX4_EN to cascade two restoring steps per BUSY cycle.
module fmadiv_iter
    import fmadiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x_sign,
    input  logic             y_sign,
    input  logic             x_zero,
    input  logic             y_zero,
    input  logic [NE-1:0]    x_exp,
    input  logic [NE-1:0]    y_exp,
    input  logic [NF-1:0]    x_fract,
    input  logic [NF-1:0]    y_fract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             q_sign,
    output logic [EW-1:0]    q_exp,
    output logic [QBITS-1:0] q_fract,
    output logic             q_sticky,
    output logic             q_dz,
    output logic             q_nv
);

    state_e        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [MW-1:0] d_q, d_d;
    logic [QW-1:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    res_t          res_q, res_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic          bit0_c;
    logic [RW-1:0] r1_c;
    logic [RW-1:0] r_step_c;
    logic [QW-1:0] q_step_c;

    fmadiv_iter_step u_step0 (
        .r        (r_q),
        .d        (d_q),
        .q_bit_c  (bit0_c),
        .r_next_c (r1_c)
    );

`ifdef FMADIV_RADIX4_EN
    logic          bit1_c;
    logic [RW-1:0] r2_c;

    fmadiv_iter_step u_step1 (
        .r        (r1_c),
        .d        (d_q),
        .q_bit_c  (bit1_c),
        .r_next_c (r2_c)
    );

    assign q_step_c = {q_q[QW-3:0], bit0_c, bit1_c};
    assign r_step_c = r2_c;
`else
    assign q_step_c = {q_q[QW-2:0], bit0_c};
    assign r_step_c = r1_c;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            d_q         <= d_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    res_d.sign   = x_sign ^ y_sign;
                    res_d.exp    = quot_exp(x_exp, y_exp);
                    res_d.sticky = 1'b0;
                    res_d.dz     = ~x_zero & y_zero;
                    res_d.nv     = x_zero & y_zero;
                    r_d          = RW'({1'b1, x_fract});
                    d_d          = {1'b1, y_fract};
                    q_d          = '0;
                    cnt_d        = '0;
                    // Zero operands bypass iteration with a cleared significand.
                    if (x_zero || y_zero) begin
                        res_d.exp = '0;
                        state_d   = DONE;
                    end else begin
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                r_d   = r_step_c;
                q_d   = q_step_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    res_d.sticky = (r_step_c != '0) | ((q_step_c & DROP_MASK) != '0);
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q_sign    = res_q.sign;
    assign q_exp     = res_q.exp;
    assign q_fract   = q_q[QW-1 -: QBITS];
    assign q_sticky  = res_q.sticky;
    assign q_dz      = res_q.dz;
    assign q_nv      = res_q.nv;

endmodule

// File: tb/tb_fmadiv_iter.sv
// Directed self-checking bench for fmadiv_iter (half precision, both radix builds).
module tb_fmadiv_iter;
    import fmadiv_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic             x_sign, y_sign, x_zero, y_zero;
    logic [NE-1:0]    x_exp, y_exp;
    logic [NF-1:0]    x_fract, y_fract;
    logic             out_valid;
    logic             out_ready;
    logic             q_sign;
    logic [EW-1:0]    q_exp;
    logic [QBITS-1:0] q_fract;
    logic             q_sticky, q_dz, q_nv;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    fmadiv_iter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_sign    (x_sign),
        .y_sign    (y_sign),
        .x_zero    (x_zero),
        .y_zero    (y_zero),
        .x_exp     (x_exp),
        .y_exp     (y_exp),
        .x_fract   (x_fract),
        .y_fract   (y_fract),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_sign    (q_sign),
        .q_exp     (q_exp),
        .q_fract   (q_fract),
        .q_sticky  (q_sticky),
        .q_dz      (q_dz),
        .q_nv      (q_nv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic xs, input logic [NE-1:0] xe, input logic [NF-1:0] xf, input logic xz,
                           input logic ys, input logic [NE-1:0] ye, input logic [NF-1:0] yf, input logic yz);
        x_sign = xs; x_exp = xe; x_fract = xf; x_zero = xz;
        y_sign = ys; y_exp = ye; y_fract = yf; y_zero = yz;
    endtask

    // Presents operands for one edge; returns #1 after that accept edge.
    task automatic drive(input logic xs, input logic [NE-1:0] xe, input logic [NF-1:0] xf, input logic xz,
                         input logic ys, input logic [NE-1:0] ye, input logic [NF-1:0] yf, input logic yz);
        @(negedge clk);
        set_ops(xs, xe, xf, xz, ys, ye, yf, yz);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts clock edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_res(input string pfx, input logic s, input logic [EW-1:0] e,
                             input logic [QBITS-1:0] f, input logic st, input logic dz, input logic nv);
        check({pfx, "_valid"},  32'(out_valid), 32'd1);
        check({pfx, "_sign"},   32'(q_sign),    32'(s));
        check({pfx, "_exp"},    32'(q_exp),     32'(e));
        check({pfx, "_fract"},  32'(q_fract),   32'(f));
        check({pfx, "_sticky"}, 32'(q_sticky),  32'(st));
        check({pfx, "_dz"},     32'(q_dz),      32'(dz));
        check({pfx, "_nv"},     32'(q_nv),      32'(nv));
    endtask

    task automatic handshake(input string pfx);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({pfx, "_hs_in_ready"},  32'(in_ready),  32'd1);
        check({pfx, "_hs_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q_exp",     32'(q_exp),     32'd0);
        check("rst_q_fract",   32'(q_fract),   32'd0);
        check("rst_q_sticky",  32'(q_sticky),  32'd0);
        check("rst_q_dz_nv",   32'({q_dz, q_nv, q_sign}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1.0 / 1.0
        drive(1'b0, 5'd15, 10'h000, 1'b0, 1'b0, 5'd15, 10'h000, 1'b0);
        check("t1_busy_in_ready", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("t1_latency", 32'(lat), 32'(ITERS));
        check_res("t1", 1'b0, 7'd15, 13'h1000, 1'b0, 1'b0, 1'b0);
        handshake("t1");

        // 1.0 / 1.5 with backpressure and ignored in_valid in DONE
        drive(1'b0, 5'd15, 10'h000, 1'b0, 1'b0, 5'd15, 10'h200, 1'b0);
        wait_valid(lat);
        check("t2_latency", 32'(lat), 32'(ITERS));
        check_res("t2", 1'b0, 7'd15, 13'h0AAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_ops(1'b1, 5'd20, 10'h3FF, 1'b0, 1'b0, 5'd3, 10'h001, 1'b0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("t2_bp_out_valid", 32'(out_valid), 32'd1);
            check("t2_bp_in_ready",  32'(in_ready),  32'd0);
            check("t2_bp_fract",     32'(q_fract),   32'h0AAA);
            check("t2_bp_exp_sign",  32'({q_sign, q_exp}), 32'd15);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("t2");
        repeat (3) @(posedge clk);
        #1;
        check("t2_no_phantom", 32'(out_valid), 32'd0);

        // -3.0 / 2.0 with a stray in_valid while BUSY
        drive(1'b1, 5'd16, 10'h200, 1'b0, 1'b0, 5'd16, 10'h000, 1'b0);
        @(negedge clk);
        set_ops(1'b0, 5'd25, 10'h155, 1'b0, 1'b1, 5'd2, 10'h0F0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check_res("t3", 1'b1, 7'd15, 13'h1800, 1'b0, 1'b0, 1'b0);
        handshake("t3");

        // zero / normal
        drive(1'b1, 5'd0, 10'h000, 1'b1, 1'b0, 5'd15, 10'h000, 1'b0);
        wait_valid(lat);
        check("t4_latency", 32'(lat), 32'd0);
        check_res("t4", 1'b1, 7'd0, 13'h0000, 1'b0, 1'b0, 1'b0);
        handshake("t4");

        // normal / zero
        drive(1'b0, 5'd15, 10'h155, 1'b0, 1'b1, 5'd0, 10'h000, 1'b1);
        wait_valid(lat);
        check("t5_latency", 32'(lat), 32'd0);
        check_res("t5", 1'b1, 7'd0, 13'h0000, 1'b0, 1'b1, 1'b0);
        handshake("t5");

        // zero / zero
        drive(1'b0, 5'd0, 10'h000, 1'b1, 1'b0, 5'd0, 10'h000, 1'b1);
        wait_valid(lat);
        check_res("t6", 1'b0, 7'd0, 13'h0000, 1'b0, 1'b0, 1'b1);
        handshake("t6");

        // reset mid-operation
        drive(1'b0, 5'd15, 10'h000, 1'b0, 1'b0, 5'd15, 10'h200, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_rst_in_ready",  32'(in_ready),  32'd1);
        check("t7_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t7_no_result", 32'(out_valid), 32'd0);

        // 2.0 / 1.0 after the abort
        drive(1'b0, 5'd16, 10'h000, 1'b0, 1'b0, 5'd15, 10'h000, 1'b0);
        wait_valid(lat);
        check("t8_latency", 32'(lat), 32'(ITERS));
        check_res("t8", 1'b0, 7'd16, 13'h1000, 1'b0, 1'b0, 1'b0);
        handshake("t8");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
